// File: rtl/pwm_cmd_sequencer.sv
// Avalon-MM master for the 3-phase centre-aligned PWM slave: power-up
// programming, per-command compare-pair loading with deadtime, commit,
// update-window tracking on the slave irq, and a commit watchdog.
module pwm_cmd_sequencer #(
  parameter logic [15:0] MAX_CTR    = 16'd2500,
  parameter logic [15:0] DEADTIME   = 16'd50,
  parameter int unsigned WDOG_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_duty0,
  input  logic [15:0] cmd_duty1,
  input  logic [15:0] cmd_duty2,
  output logic [3:0]  m_addr,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitreq,
  input  logic        pwm_irq,
  output logic        fault,
  input  logic        fault_clr
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_ARMED,
    S_TRIP,
    S_FAULT
  } state_t;

  localparam logic [7:0] LIMIT8 = 8'(WDOG_LIMIT);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_idx, w_idx_nxt, w_idx_inc;
  logic        r_write, w_write_nxt;
  logic [3:0]  r_addr, w_addr_nxt;
  logic [15:0] r_data, w_data_nxt;
  logic [7:0]  r_wdog, w_wdog_nxt, w_wdog_inc;
  logic        r_fault, w_fault_nxt;
  logic [15:0] r_duty0, r_duty1, r_duty2;
  logic        w_latch;
  logic        w_done;
  logic        w_trip;

  function automatic logic [15:0] f_clamp(input logic [15:0] d);
    return (d > MAX_CTR) ? MAX_CTR : d;
  endfunction

  function automatic logic [15:0] f_low(input logic [15:0] d);
    return (d < DEADTIME) ? 16'd0 : (d - DEADTIME);
  endfunction

  function automatic logic [15:0] f_high(input logic [15:0] d);
    logic [16:0] s;
    s = {1'b0, d} + {1'b0, DEADTIME};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [3:0] f_init_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return 4'h8;
      3'd1:    return 4'hA;
      3'd2:    return 4'hB;
      3'd3:    return 4'hC;
      3'd4:    return 4'hD;
      default: return 4'h9;
    endcase
  endfunction

  function automatic logic [15:0] f_init_data(input logic [2:0] idx);
    case (idx)
      3'd0:    return MAX_CTR;
      3'd1:    return 16'd1;
      3'd2:    return 16'd0;
      3'd3:    return 16'd1;
      3'd4:    return 16'd0;
      default: return 16'd1;
    endcase
  endfunction

  // Even index = low compare, odd = high compare; idx[2:1] selects the phase.
  function automatic logic [15:0] f_load_data(input logic [2:0] idx, input logic [15:0] d0,
                                              input logic [15:0] d1, input logic [15:0] d2);
    logic [15:0] d;
    case (idx[2:1])
      2'd0:    d = d0;
      2'd1:    d = d1;
      default: d = d2;
    endcase
    return idx[0] ? f_high(d) : f_low(d);
  endfunction

  assign w_done     = r_write & ~m_waitreq;
  assign w_idx_inc  = r_idx + 3'd1;
  assign w_wdog_inc = (r_wdog == 8'hFF) ? r_wdog : (r_wdog + 8'd1);
  assign w_trip     = pwm_irq & (w_wdog_inc >= LIMIT8);

  assign m_write     = r_write;
  assign m_addr      = r_addr;
  assign m_writedata = {16'h0000, r_data};
  assign fault       = r_fault;

  // State and bus registers; reset drops any write in flight immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wdog  <= '0;
      r_fault <= 1'b0;
      r_duty0 <= '0;
      r_duty1 <= '0;
      r_duty2 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_write <= w_write_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_wdog  <= w_wdog_nxt;
      r_fault <= w_fault_nxt;
      if (w_latch) begin
        r_duty0 <= f_clamp(cmd_duty0);
        r_duty1 <= f_clamp(cmd_duty1);
        r_duty2 <= f_clamp(cmd_duty2);
      end
    end
  end

  // Next state plus the next bus word; a write is only replaced once it completes.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_write_nxt = r_write;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_wdog_nxt  = r_wdog;
    w_fault_nxt = r_fault;
    w_latch     = 1'b0;
    cmd_ready   = 1'b0;

    case (r_state)
      S_INIT: begin
        if (!r_write) begin
          w_write_nxt = 1'b1;
          w_addr_nxt  = f_init_addr(r_idx);
          w_data_nxt  = f_init_data(r_idx);
        end else if (w_done) begin
          if (r_idx == 3'd5) begin
            w_write_nxt = 1'b0;
            w_idx_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt  = w_idx_inc;
            w_addr_nxt = f_init_addr(w_idx_inc);
            w_data_nxt = f_init_data(w_idx_inc);
          end
        end
      end

      S_IDLE: begin
        // Ready is withheld when a watchdog trip lands in the same cycle.
        cmd_ready = ~w_trip;
        if (pwm_irq) w_wdog_nxt = w_wdog_inc;
        if (w_trip) begin
          w_state_nxt = S_TRIP;
          w_write_nxt = 1'b1;
          w_addr_nxt  = 4'h9;
          w_data_nxt  = 16'd0;
        end else if (cmd_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = S_LOAD;
          w_idx_nxt   = '0;
          w_write_nxt = 1'b1;
          w_addr_nxt  = 4'h0;
          w_data_nxt  = f_low(f_clamp(cmd_duty0));
        end
      end

      S_LOAD: begin
        if (w_done) begin
          if (r_idx == 3'd5) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_COMMIT;
            w_addr_nxt  = 4'hF;
            w_data_nxt  = 16'd1;
          end else begin
            w_idx_nxt  = w_idx_inc;
            w_addr_nxt = {1'b0, w_idx_inc};
            w_data_nxt = f_load_data(w_idx_inc, r_duty0, r_duty1, r_duty2);
          end
        end
      end

      S_COMMIT: begin
        if (w_done) begin
          w_write_nxt = 1'b0;
          w_wdog_nxt  = '0;
          w_state_nxt = S_ARMED;
        end
      end

      S_ARMED: begin
        if (pwm_irq) begin
          w_wdog_nxt = w_wdog_inc;
          if (w_trip) begin
            w_state_nxt = S_TRIP;
            w_write_nxt = 1'b1;
            w_addr_nxt  = 4'h9;
            w_data_nxt  = 16'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_TRIP: begin
        if (w_done) begin
          w_write_nxt = 1'b0;
          w_fault_nxt = 1'b1;
          w_state_nxt = S_FAULT;
        end
      end

      S_FAULT: begin
        if (fault_clr) begin
          w_fault_nxt = 1'b0;
          w_wdog_nxt  = '0;
          w_idx_nxt   = '0;
          w_state_nxt = S_INIT;
        end
      end

      default: w_state_nxt = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_pwm_cmd_sequencer.sv
// Scoreboard bench for pwm_cmd_sequencer: expected bus writes are queued as
// stimulus is driven and compared as the DUT completes them.
module tb_pwm_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_duty0, cmd_duty1, cmd_duty2;
  logic [3:0]  m_addr;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitreq;
  logic        pwm_irq;
  logic        fault;
  logic        fault_clr;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int last_wr_cyc = 0;
  logic [63:0] sb_q[$];

  pwm_cmd_sequencer #(
    .MAX_CTR   (16'd2500),
    .DEADTIME  (16'd50),
    .WDOG_LIMIT(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_duty0  (cmd_duty0),
    .cmd_duty1  (cmd_duty1),
    .cmd_duty2  (cmd_duty2),
    .m_addr     (m_addr),
    .m_write    (m_write),
    .m_writedata(m_writedata),
    .m_waitreq  (m_waitreq),
    .pwm_irq    (pwm_irq),
    .fault      (fault),
    .fault_clr  (fault_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] wr(input logic [3:0] a, input logic [31:0] d);
    return {28'd0, a, d};
  endfunction

  function automatic logic [15:0] m_lo(input int d);
    int c;
    c = (d > 2500) ? 2500 : d;
    return (c < 50) ? 16'd0 : 16'(c - 50);
  endfunction

  function automatic logic [15:0] m_hi(input int d);
    int c;
    c = ((d > 2500) ? 2500 : d) + 50;
    return (c > 65535) ? 16'hFFFF : 16'(c);
  endfunction

  // Completed writes are checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && m_write && !m_waitreq) begin
      last_wr_cyc = cyc;
      if (sb_q.size() == 0) chk("wr_unexpected", {28'd0, m_addr, m_writedata}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("wr", {28'd0, m_addr, m_writedata}, sb_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_irq();
    pwm_irq = 1'b1;
    step();
    pwm_irq = 1'b0;
  endtask

  task automatic push_init();
    sb_q.push_back(wr(4'h8, 32'd2500));
    sb_q.push_back(wr(4'hA, 32'd1));
    sb_q.push_back(wr(4'hB, 32'd0));
    sb_q.push_back(wr(4'hC, 32'd1));
    sb_q.push_back(wr(4'hD, 32'd0));
    sb_q.push_back(wr(4'h9, 32'd1));
  endtask

  task automatic push_cmd(input int d0, input int d1, input int d2);
    sb_q.push_back(wr(4'h0, {16'd0, m_lo(d0)}));
    sb_q.push_back(wr(4'h1, {16'd0, m_hi(d0)}));
    sb_q.push_back(wr(4'h2, {16'd0, m_lo(d1)}));
    sb_q.push_back(wr(4'h3, {16'd0, m_hi(d1)}));
    sb_q.push_back(wr(4'h4, {16'd0, m_lo(d2)}));
    sb_q.push_back(wr(4'h5, {16'd0, m_hi(d2)}));
    sb_q.push_back(wr(4'hF, 32'd1));
  endtask

  task automatic drive_cmd(input int d0, input int d1, input int d2);
    cmd_duty0 = 16'(d0);
    cmd_duty1 = 16'(d1);
    cmd_duty2 = 16'(d2);
    cmd_valid = 1'b1;
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < lim) begin
      step();
      n++;
    end
    chk("drain_left", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    int c0;
    logic [3:0]  sa;
    logic [31:0] sd;
    logic found;

    reset = 1'b1; cmd_valid = 1'b0; cmd_duty0 = '0; cmd_duty1 = '0; cmd_duty2 = '0;
    m_waitreq = 1'b0; pwm_irq = 1'b0; fault_clr = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_write", 64'(m_write), 64'd0);
    chk("rst_addr", 64'(m_addr), 64'd0);
    chk("rst_data", 64'(m_writedata), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);

    // Power-up programming on consecutive cycles
    push_init();
    c0 = cyc;
    reset = 1'b0;
    drain(30);
    chk("init_span", 64'(last_wr_cyc - c0), 64'd6);
    chk("idle_ready", 64'(cmd_ready), 64'd1);

    // Basic command with clamp and deadtime floor, latency check
    push_cmd(1000, 30, 3000);
    drive_cmd(1000, 30, 3000);
    c0 = cyc;
    step();
    cmd_valid = 1'b0;
    chk("load_ready", 64'(cmd_ready), 64'd0);
    drain(30);
    chk("commit_latency", 64'(last_wr_cyc - c0), 64'd7);
    chk("armed_ready", 64'(cmd_ready), 64'd0);
    repeat (4) step();
    chk("armed_ready_hold", 64'(cmd_ready), 64'd0);
    pulse_irq();
    chk("post_irq_ready", 64'(cmd_ready), 64'd1);

    // Three-cycle stall on the 0x2 write
    push_cmd(500, 40, 60000);
    drive_cmd(500, 40, 60000);
    step();
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_write && m_addr == 4'h2) found = 1'b1;
      else step();
    end
    chk("stall_reach", 64'(found), 64'd1);
    m_waitreq = 1'b1;
    sa = m_addr;
    sd = m_writedata;
    repeat (3) begin
      step();
      chk("stall_write", 64'(m_write), 64'd1);
      chk("stall_addr", 64'(m_addr), 64'(sa));
      chk("stall_data", 64'(m_writedata), 64'(sd));
    end
    m_waitreq = 1'b0;
    drain(30);
    pulse_irq();

    // Reset in the middle of LOAD: write drops at once, INIT re-runs, no stale writes
    push_cmd(1200, 1300, 1400);
    drive_cmd(1200, 1300, 1400);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("midrst_write", 64'(m_write), 64'd0);
    chk("midrst_addr", 64'(m_addr), 64'd0);
    sb_q.delete();
    push_init();
    step();
    step();
    reset = 1'b0;
    drain(30);
    repeat (5) step();
    chk("midrst_ready", 64'(cmd_ready), 64'd1);

    // Watchdog: seven irqs tolerated, eighth trips and beats a same-cycle command
    for (int i = 0; i < 7; i++) begin
      pulse_irq();
      repeat (3) step();
    end
    chk("wdog_pre_fault", 64'(fault), 64'd0);
    sb_q.push_back(wr(4'h9, 32'd0));
    drive_cmd(700, 700, 700);
    pulse_irq();
    cmd_valid = 1'b0;
    drain(10);
    step();
    chk("trip_fault", 64'(fault), 64'd1);
    chk("trip_ready", 64'(cmd_ready), 64'd0);
    drive_cmd(900, 900, 900);
    repeat (3) step();
    pulse_irq();
    repeat (3) step();
    cmd_valid = 1'b0;
    chk("fault_sticky", 64'(fault), 64'd1);

    // fault_clr re-runs the full programming sequence
    push_init();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr_fault", 64'(fault), 64'd0);
    drain(30);
    step();
    chk("clr_ready", 64'(cmd_ready), 64'd1);

    // Steady operation: a command every window keeps the watchdog from tripping
    for (int w = 0; w < 12; w++) begin
      int d0, d1, d2;
      d0 = int'($urandom_range(0, 4000));
      d1 = int'($urandom_range(0, 120));
      d2 = int'($urandom_range(2000, 65535));
      push_cmd(d0, d1, d2);
      drive_cmd(d0, d1, d2);
      step();
      cmd_valid = 1'b0;
      drain(30);
      repeat (20) step();
      pulse_irq();
      step();
    end
    chk("steady_fault", 64'(fault), 64'd0);
    chk("steady_ready", 64'(cmd_ready), 64'd1);

    repeat (5) step();
    chk("sb_empty_end", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
